nonce_scheduler: RTL and testbench
==================================

// Module: nonce_scheduler
// PURPOSE
// Sequences the pipelined keccak core for a mining job. Takes a job (start/end nonce) once the
// serial loader has assembled the 608-bit header, latches the header into the core, issues one
// nonce per cycle, and aligns the core's gn_match with a delayed copy of the issued nonce. Reports
// the first matching nonce or range exhaustion. Sits between the serial loader and the keccak core.
// PARAMETERS
// CORE_LAT  24  cycles from core_nonce/core_valid sampled to the corresponding gn_match (>=1)
// NONCE_W   32  nonce width
// PORTS
// clk            in   1        core clock (PLL output domain)
// reset          in   1        synchronous, active-high
// job_valid      in   1        new job request; nonce range on job_start/job_end
// job_start      in   NONCE_W  first nonce (inclusive)
// job_end        in   NONCE_W  last nonce (inclusive)
// job_ready      out  1        1 in IDLE, FOUND, DONE
// hdr_we         out  1        1-cycle pulse: core latches header/target
// core_nonce     out  NONCE_W  nonce presented to core
// core_valid     out  1        core_nonce is a live candidate this cycle
// gn_match       in   1        core match flag, CORE_LAT cycles after issue
// found          out  1        held high: match found
// found_nonce    out  NONCE_W  nonce that produced the match
// done           out  1        held high: range exhausted, no match
// busy           out  1        1 in LOAD, RUN, DRAIN
// BEHAVIOUR
// - Reset: state=IDLE; all outputs 0 except job_ready=1; delay-line valid bits cleared.
// - States: IDLE, LOAD, RUN, DRAIN, FOUND, DONE.
// - Accept: job_valid & job_ready -> LOAD next cycle; cur<=job_start, last<=job_end; found/done clear.
// - LOAD (1 cycle): hdr_we=1, core_valid=0 -> RUN.
// - RUN: core_valid=1, core_nonce=cur; cur<=cur+1 mod 2^NONCE_W. When cur==last is issued -> DRAIN.
//   start==end: exactly one nonce. end<start: range wraps through all-ones to 0. Never issue >2^N.
// - Delay line: CORE_LAT-deep shift of {core_valid, core_nonce}; tail aligns with gn_match.
//   gn_match counts only when tail valid=1; otherwise ignored (stale/unloaded core).
// - Match (tail valid & gn_match) in RUN or DRAIN -> FOUND next cycle; found_nonce<=tail nonce;
//   issuing stops same cycle; delay-line valid bits flushed; first match wins, later ones dropped.
// - DRAIN: core_valid=0; after CORE_LAT cycles with no match -> DONE.
// - FOUND/DONE: flags held until next accepted job or reset.
// - job_valid in LOAD/RUN/DRAIN: abort; flush valid bits, take new range, -> LOAD next cycle.
// - Match and abort same cycle: abort wins, match discarded.
// - Reset mid-job: returns to IDLE next edge, no flag asserted, no further core_valid.
// - Total latency, job accept to DONE for N nonces: 1 + N + CORE_LAT cycles.
// TESTING
// - job 0x10..0x13, no match -> 4 core_valid cycles nonces 0x10..0x13, done at accept+1+4+CORE_LAT.
// - job 0..0xFF, gn_match when tail=0x42 -> found=1, found_nonce=0x42, core_valid low after.
// - job 0xFFFFFFFE..0x00000001 -> issued FFFFFFFE,FFFFFFFF,0,1 then done.
// - gn_match forced high while idle and during LOAD -> no found; stale bits ignored.
// - abort: new job 0x500..0x500 mid-RUN with match pending -> old match lost, one nonce 0x500.
// - reset asserted during DRAIN -> IDLE, found=done=0, job_ready=1 next cycle.

Source files
------------

// File: rtl/nonce_scheduler.sv
// Mining-job sequencer for the pipelined keccak core: loads the header, issues one nonce per cycle,
// and matches gn_match against a CORE_LAT-deep delayed copy of each issued nonce.
module nonce_scheduler #(
  parameter int CORE_LAT = 24,
  parameter int NONCE_W  = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               job_valid,
  input  logic [NONCE_W-1:0] job_start,
  input  logic [NONCE_W-1:0] job_end,
  output logic               job_ready,
  output logic               hdr_we,
  output logic [NONCE_W-1:0] core_nonce,
  output logic               core_valid,
  input  logic               gn_match,
  output logic               found,
  output logic [NONCE_W-1:0] found_nonce,
  output logic               done,
  output logic               busy
);

  localparam int CNT_W = $clog2(CORE_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_FOUND = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [NONCE_W-1:0] cur_q, cur_d;
  logic [NONCE_W-1:0] last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NONCE_W-1:0] core_nonce_q, core_nonce_d;
  logic               core_valid_q, core_valid_d;
  logic               hdr_we_q, hdr_we_d;
  logic               found_q, found_d;
  logic [NONCE_W-1:0] found_nonce_q, found_nonce_d;
  logic               done_q, done_d;
  logic               job_ready_q, job_ready_d;
  logic               busy_q, busy_d;
  logic [CORE_LAT-1:0] dl_v_q, dl_v_d;
  logic [NONCE_W-1:0]  dl_n_q [CORE_LAT];
  logic [NONCE_W-1:0]  dl_n_d [CORE_LAT];
  logic               tail_hit;

  // The tail of the delay line lines up with the gn_match the core reports for that nonce.
  assign tail_hit = dl_v_q[CORE_LAT-1] & gn_match;

  always_comb begin
    state_d       = state_q;
    cur_d         = cur_q;
    last_d        = last_q;
    cnt_d         = cnt_q;
    core_nonce_d  = core_nonce_q;
    core_valid_d  = 1'b0;
    hdr_we_d      = 1'b0;
    found_d       = found_q;
    found_nonce_d = found_nonce_q;
    done_d        = done_q;
    dl_v_d[0]     = core_valid_q;
    dl_n_d[0]     = core_nonce_q;
    for (int i = 1; i < CORE_LAT; i++) begin
      dl_v_d[i] = dl_v_q[i-1];
      dl_n_d[i] = dl_n_q[i-1];
    end

    // A new job (accept or abort) outranks any match seen in the same cycle.
    if (job_valid) begin
      state_d       = S_LOAD;
      cur_d         = job_start;
      last_d        = job_end;
      hdr_we_d      = 1'b1;
      found_d       = 1'b0;
      found_nonce_d = {NONCE_W{1'b0}};
      done_d        = 1'b0;
      dl_v_d        = {CORE_LAT{1'b0}};
    end else begin
      case (state_q)
        S_LOAD: begin
          state_d      = S_RUN;
          core_valid_d = 1'b1;
          core_nonce_d = cur_q;
          cur_d        = cur_q + NONCE_W'(1);
        end
        S_RUN, S_DRAIN: begin
          if (tail_hit) begin
            state_d       = S_FOUND;
            found_d       = 1'b1;
            found_nonce_d = dl_n_q[CORE_LAT-1];
            dl_v_d        = {CORE_LAT{1'b0}};
          end else if (state_q == S_RUN) begin
            if (core_nonce_q == last_q) begin
              state_d = S_DRAIN;
              cnt_d   = {CNT_W{1'b0}};
            end else begin
              core_valid_d = 1'b1;
              core_nonce_d = cur_q;
              cur_d        = cur_q + NONCE_W'(1);
            end
          end else if (cnt_q == CNT_W'(CORE_LAT - 1)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_IDLE, S_FOUND, S_DONE: begin
          state_d = state_q;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    job_ready_d = (state_d == S_IDLE) || (state_d == S_FOUND) || (state_d == S_DONE);
    busy_d      = ~job_ready_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cur_q         <= {NONCE_W{1'b0}};
      last_q        <= {NONCE_W{1'b0}};
      cnt_q         <= {CNT_W{1'b0}};
      core_nonce_q  <= {NONCE_W{1'b0}};
      core_valid_q  <= 1'b0;
      hdr_we_q      <= 1'b0;
      found_q       <= 1'b0;
      found_nonce_q <= {NONCE_W{1'b0}};
      done_q        <= 1'b0;
      job_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      dl_v_q        <= {CORE_LAT{1'b0}};
    end else begin
      state_q       <= state_d;
      cur_q         <= cur_d;
      last_q        <= last_d;
      cnt_q         <= cnt_d;
      core_nonce_q  <= core_nonce_d;
      core_valid_q  <= core_valid_d;
      hdr_we_q      <= hdr_we_d;
      found_q       <= found_d;
      found_nonce_q <= found_nonce_d;
      done_q        <= done_d;
      job_ready_q   <= job_ready_d;
      busy_q        <= busy_d;
      dl_v_q        <= dl_v_d;
      dl_n_q        <= dl_n_d;
    end
  end

  assign job_ready   = job_ready_q;
  assign hdr_we      = hdr_we_q;
  assign core_nonce  = core_nonce_q;
  assign core_valid  = core_valid_q;
  assign found       = found_q;
  assign found_nonce = found_nonce_q;
  assign done        = done_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_nonce_scheduler.sv
// Randomized bench for nonce_scheduler: a behavioural core drives gn_match from the issued nonces,
// and each job's outcome is predicted from the range/target list with plain arithmetic.
module tb_nonce_scheduler;
  localparam int L = 6;
  localparam int W = 32;

  logic         clk, reset, job_valid, gn_match;
  logic [W-1:0] job_start, job_end;
  logic         job_ready, hdr_we, core_valid, found, done, busy;
  logic [W-1:0] core_nonce, found_nonce;

  nonce_scheduler #(.CORE_LAT(L), .NONCE_W(W)) dut (
    .clk(clk), .reset(reset), .job_valid(job_valid), .job_start(job_start), .job_end(job_end),
    .job_ready(job_ready), .hdr_we(hdr_we), .core_nonce(core_nonce), .core_valid(core_valid),
    .gn_match(gn_match), .found(found), .found_nonce(found_nonce), .done(done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           n_cmp = 0;
  int           n_bad = 0;
  bit           pv [L];
  logic [W-1:0] pn [L];
  logic [W-1:0] tgts [$];
  bit           force_gm = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit is_tgt(input logic [W-1:0] n);
    foreach (tgts[i]) if (tgts[i] == n) return 1'b1;
    return 1'b0;
  endfunction

  // One clock; the core model answers each nonce exactly L cycles after it was presented.
  task automatic step();
    bit           cv;
    logic [W-1:0] cn;
    cv = core_valid;
    cn = core_nonce;
    @(posedge clk);
    #1;
    for (int i = L - 1; i > 0; i--) begin
      pv[i] = pv[i-1];
      pn[i] = pn[i-1];
    end
    pv[0] = cv;
    pn[0] = cn;
    gn_match = pv[L-1] ? is_tgt(pn[L-1]) : (force_gm | 1'($urandom_range(0, 1)));
  endtask

  task automatic run_job(input string tag, input logic [W-1:0] s, input logic [W-1:0] e);
    logic [W-1:0] diff, first_cv, first_hdr;
    longint       n, k, exp_lat, exp_cnt;
    int           cyc, hdr_cnt, busy_low, bad_seq, late_cv, budget;
    logic [W-1:0] issued [$];
    bit           exp_found;
    diff = e - s;
    n = longint'(diff) + 1;
    k = -1;
    for (longint i = 0; i < n; i++) begin
      if (is_tgt(s + W'(i))) begin
        k = i;
        break;
      end
    end
    exp_found = (k >= 0);
    exp_lat   = exp_found ? k + L + 2 : n + L + 1;
    exp_cnt   = exp_found ? ((k + L + 1 < n) ? k + L + 1 : n) : n;
    budget    = int'(n) + L + 20;

    job_start = s;
    job_end   = e;
    job_valid = 1'b1;
    step();
    job_valid = 1'b0;
    cyc = 1;
    first_hdr = W'(hdr_we);
    first_cv  = W'(core_valid);
    hdr_cnt = 0;
    busy_low = 0;
    while (!(found || done) && cyc < budget) begin
      if (core_valid) issued.push_back(core_nonce);
      if (hdr_we) hdr_cnt++;
      if (!busy) busy_low++;
      step();
      cyc++;
    end
    bad_seq = 0;
    foreach (issued[i]) if (issued[i] !== s + W'(i)) bad_seq++;

    chk({tag, " latency"}, 64'(cyc - 1), 64'(exp_lat));
    chk({tag, " found"}, 64'(found), 64'(exp_found));
    chk({tag, " done"}, 64'(done), 64'(!exp_found));
    chk({tag, " found_nonce"}, 64'(found_nonce), exp_found ? 64'(s + W'(k)) : 64'd0);
    chk({tag, " issue_count"}, 64'(issued.size()), 64'(exp_cnt));
    chk({tag, " issue_seq"}, 64'(bad_seq), 64'd0);
    chk({tag, " load_hdr_we"}, 64'(first_hdr), 64'd1);
    chk({tag, " load_core_valid"}, 64'(first_cv), 64'd0);
    chk({tag, " hdr_pulses"}, 64'(hdr_cnt), 64'd1);
    chk({tag, " busy_while_active"}, 64'(busy_low), 64'd0);
    chk({tag, " ready_at_end"}, 64'({job_ready, busy}), 64'b10);

    late_cv = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (core_valid) late_cv++;
    end
    chk({tag, " no_issue_after"}, 64'(late_cv), 64'd0);
    chk({tag, " flags_held"}, 64'({found, done}), 64'({exp_found, !exp_found}));
  endtask

  initial begin
    logic [W-1:0] s, e, len;
    int           late;
    for (int i = 0; i < L; i++) begin
      pv[i] = 1'b0;
      pn[i] = '0;
    end
    reset = 1'b1;
    job_valid = 1'b0;
    job_start = '0;
    job_end = '0;
    gn_match = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    chk("reset outputs", 64'({job_ready, hdr_we, core_valid, found, done, busy}), 64'b100000);
    chk("reset nonces", 64'({core_nonce, found_nonce}), 64'd0);

    // gn_match held high while idle, in LOAD and whenever the tail is empty
    force_gm = 1'b1;
    repeat (5) step();
    chk("idle_gn_match found", 64'({found, done}), 64'd0);
    run_job("basic_forced", 32'h10, 32'h13);
    force_gm = 1'b0;

    tgts = '{32'h42};
    run_job("match42", 32'h0, 32'hFF);
    tgts = '{};
    run_job("wrap", 32'hFFFF_FFFE, 32'h1);
    run_job("single", 32'h77, 32'h77);
    tgts = '{32'h77};
    run_job("single_hit", 32'h77, 32'h77);

    // abort lands on the same edge as a pending match for 0x105
    tgts = '{32'h105};
    job_start = 32'h100;
    job_end = 32'h1FF;
    job_valid = 1'b1;
    step();
    job_valid = 1'b0;
    repeat (6 + L) step();
    chk("abort pre found", 64'(found), 64'd0);
    chk("abort gn_match pending", 64'(gn_match), 64'd1);
    run_job("abort_new", 32'h500, 32'h500);

    // reset while draining
    tgts = '{};
    job_start = 32'h10;
    job_end = 32'h13;
    job_valid = 1'b1;
    step();
    job_valid = 1'b0;
    repeat (7) step();
    chk("drain busy before reset", 64'({busy, core_valid}), 64'b10);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("reset_drain outputs", 64'({job_ready, found, done, busy, core_valid}), 64'b10000);
    late = 0;
    for (int i = 0; i < L + 5; i++) begin
      step();
      if (found || done || core_valid) late++;
    end
    chk("reset_drain stays idle", 64'(late), 64'd0);

    for (int j = 0; j < 8; j++) begin
      len = W'($urandom_range(1, 40));
      s = (j % 2 == 0) ? 32'hFFFF_FFFF - W'($urandom_range(0, 20)) : W'($urandom);
      e = s + len - 32'd1;
      tgts = '{};
      case ($urandom_range(0, 2))
        0: tgts.push_back(e + 32'd5);
        1: tgts.push_back(s + W'($urandom_range(0, int'(len) - 1)));
        default: begin
          tgts.push_back(s + W'($urandom_range(0, int'(len) - 1)));
          tgts.push_back(s + W'($urandom_range(0, int'(len) - 1)));
        end
      endcase
      run_job($sformatf("rand%0d", j), s, e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
